// File: rtl/pipearch_mem_pkg.sv
// Shared definitions for the memory subsystem: reader FSM states, the
// offset/length descriptor used by both the BRAM reader and writer, and the
// bit positions of those fields inside the 32-bit configuration register.
package pipearch_mem_pkg;

    // Reader control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_read_bram_state;

    // Region descriptor: where a transfer starts and how many lines it covers
    typedef struct packed {
        logic [15:0] length;
        logic [15:0] offset;
    } bram_access_properties_t;

    // Field placement inside configreg
    localparam int CFG_OFFSET_LSB  = 0;
    localparam int CFG_LENGTH_LSB  = 16;
    localparam int CFG_FIELD_WIDTH = 16;

    // Splits a raw configuration word into its offset/length descriptor
    function automatic bram_access_properties_t decode_configreg(input logic [31:0] cfg);
        bram_access_properties_t props;
        props.offset = cfg[CFG_OFFSET_LSB +: CFG_FIELD_WIDTH];
        props.length = cfg[CFG_LENGTH_LSB +: CFG_FIELD_WIDTH];
        return props;
    endfunction

    // Population count of a small valid-bit vector
    function automatic int count_ones(input logic [7:0] bits);
        int total;
        total = 0;
        for (int i = 0; i < 8; i++) begin
            total = total + int'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/read_bram_skid_fifo.sv
// Small synchronous skid FIFO that catches BRAM read data. When it is empty a
// line pushed and popped in the same cycle passes straight through, so the
// reader keeps one line per cycle without paying an extra cycle of latency.
module read_bram_skid_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          avail,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  bypass;
    logic                  store;
    logic                  take;

    // Decide whether a line is stored, taken from storage, or passes straight through
    always_comb begin
        bypass   = push && pop && (count == '0);
        store    = push && !bypass;
        take     = pop && !bypass;
        avail    = (count != '0) || push;
        pop_data = (count == '0) ? push_data : storage[rd_ptr];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (take) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(store) - CNT_W'(take);
        end
    end

    // Line storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (store) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/read_bram.sv
// Streams a contiguous BRAM region to a write-style stream with almostfull
// backpressure. Reads are only issued while the skid FIFO has room for every
// outstanding read, so returning data always finds space.
// Optional feature macro: READ_BRAM_STATS_EN adds the stall_cycles counter.
module read_bram
    import pipearch_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    input  logic [31:0]           configreg,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_we,
    output logic [DATA_WIDTH-1:0] out_wdata,
    input  logic                  out_almostfull,
    output logic                  op_done,
    output logic                  busy
`ifdef READ_BRAM_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    t_read_bram_state        state;
    t_read_bram_state        state_next;
    bram_access_properties_t cfg;
    bram_access_properties_t start_cfg;
    logic [15:0]             issued;
    logic [15:0]             emitted;
    logic [READ_LATENCY-1:0] inflight_sr;
    logic                    start_accept;
    logic                    issue_credit;
    logic                    all_emitted;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_avail;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic [CNT_W-1:0]        fifo_count;

    // Read issue, credit check and stream-side handshake decisions
    always_comb begin
        start_cfg    = decode_configreg(configreg);
        start_accept = (state == IDLE) && op_start;
        issue_credit = (int'(fifo_count) + count_ones(8'(inflight_sr))) < FIFO_DEPTH;
        mem_re       = (state == ISSUE) && (issued != cfg.length) && issue_credit;
        mem_raddr    = ADDR_WIDTH'(32'(cfg.offset) + 32'(issued));
        fifo_push    = inflight_sr[READ_LATENCY-1];
        fifo_pop     = fifo_avail && !out_almostfull;
        all_emitted  = ({1'b0, emitted} + 17'(fifo_pop)) == {1'b0, cfg.length};
        busy         = (state != IDLE);
    end

    // Next-state logic; completion is detected on the cycle of the final pop
    // so that op_done (registered from DONE) lands right after the last line
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (op_start) begin
                    state_next = (start_cfg.length == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued == cfg.length) begin
                    state_next = all_emitted ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (all_emitted) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and the one-cycle completion pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            op_done <= 1'b0;
        end else begin
            state   <= state_next;
            op_done <= (state == DONE);
        end
    end

    // Capture the region on an accepted start and advance the issue/emit counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg     <= '0;
            issued  <= '0;
            emitted <= '0;
        end else if (start_accept) begin
            cfg     <= start_cfg;
            issued  <= '0;
            emitted <= '0;
        end else begin
            issued  <= issued + 16'(mem_re);
            emitted <= emitted + 16'(fifo_pop);
        end
    end

    // Valid shift register mirroring the BRAM read pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_sr <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | READ_LATENCY'(mem_re);
        end
    end

    // Registered output stage fed by each FIFO pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_we    <= 1'b0;
            out_wdata <= '0;
        end else begin
            out_we <= fifo_pop;
            if (fifo_pop) begin
                out_wdata <= fifo_rdata;
            end
        end
    end

    read_bram_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .avail     (fifo_avail),
        .count     (fifo_count)
    );

`ifdef READ_BRAM_STATS_EN
    // Saturating count of cycles where buffered lines are held back by the consumer
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (start_accept) begin
            stall_cycles <= '0;
        end else if (busy && (fifo_count != '0) && out_almostfull && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_bram.sv
// Self-checking bench for read_bram: a table of transfers plus hand-written
// corner sequences, checked against a line-order reference model.
`timescale 1ns/1ps
module tb_read_bram;

    localparam int DATA_WIDTH   = 512;
    localparam int ADDR_WIDTH   = 16;
    localparam int READ_LATENCY = 2;
    localparam int FIFO_DEPTH   = 4;
    localparam int MAX_REL      = 4096;
    localparam int NUM_VEC      = 7;

    typedef struct {
        logic [15:0] offset;
        logic [15:0] length;
        bit          afRandom;
        int          expDone;
    } vector_t;

    logic                  clk;
    logic                  reset;
    logic                  op_start;
    logic [31:0]           configreg;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_we;
    logic [DATA_WIDTH-1:0] out_wdata;
    logic                  out_almostfull;
    logic                  op_done;
    logic                  busy;
`ifdef READ_BRAM_STATS_EN
    logic [31:0]           stall_cycles;
`endif

    int vectorsApplied = 0;
    int miscompares    = 0;
    int cyc            = 0;
    int startCyc       = 0;
    int relNow;
    bit monEn          = 0;
    bit afMode         = 0;
    bit afPrev         = 0;
    int afViol         = 0;

    logic [15:0]           addrQ  [$];
    int                    reCycQ [$];
    logic [DATA_WIDTH-1:0] dataQ  [$];
    int                    weCycQ [$];
    int                    doneQ  [$];
    bit                    busyAt [MAX_REL];

    logic [DATA_WIDTH-1:0] rdPipe [READ_LATENCY];
    vector_t               vec    [NUM_VEC];

    read_bram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .op_start       (op_start),
        .configreg      (configreg),
        .mem_re         (mem_re),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .out_we         (out_we),
        .out_wdata      (out_wdata),
        .out_almostfull (out_almostfull),
        .op_done        (op_done),
        .busy           (busy)
`ifdef READ_BRAM_STATS_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Content of every BRAM line is a fixed function of its address
    function automatic logic [DATA_WIDTH-1:0] lineOf(input logic [15:0] a);
        logic [DATA_WIDTH-1:0] v;
        for (int k = 0; k < DATA_WIDTH / 32; k++) begin
            v[k*32 +: 32] = {16'(a ^ 16'(k * 4951)), 16'(a + 16'(k))};
        end
        return v;
    endfunction

    // Expected completion cycle for an unthrottled transfer
    function automatic int expDoneOf(input int len);
        return (len == 0) ? 2 : 2 + READ_LATENCY + len;
    endfunction

    // BRAM model: data appears READ_LATENCY cycles after the read enable
    always @(posedge clk) begin
        rdPipe[0] <= mem_re ? lineOf(mem_raddr) : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rdPipe[i] <= rdPipe[i-1];
        end
    end
    assign mem_rdata = rdPipe[READ_LATENCY-1];

    // Monitor: record events with cycle numbers relative to the op_start cycle
    always @(negedge clk) begin
        if (monEn) begin
            relNow = cyc - startCyc;
            if (mem_re === 1'b1) begin
                addrQ.push_back(mem_raddr);
                reCycQ.push_back(relNow);
            end
            if (out_we === 1'b1) begin
                dataQ.push_back(out_wdata);
                weCycQ.push_back(relNow);
                if (afPrev) afViol++;
            end
            if (op_done === 1'b1) doneQ.push_back(relNow);
            if (relNow >= 0 && relNow < MAX_REL) busyAt[relNow] = busy;
            afPrev = out_almostfull;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkLine(input string name, input logic [DATA_WIDTH-1:0] actual,
                             input logic [DATA_WIDTH-1:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        addrQ.delete();
        reCycQ.delete();
        dataQ.delete();
        weCycQ.delete();
        doneQ.delete();
        for (int i = 0; i < MAX_REL; i++) busyAt[i] = 1'b0;
        afViol   = 0;
        afPrev   = 1'b0;
        startCyc = cyc;
        monEn    = 1'b1;
    endtask

    // Advance one cycle; new inputs land 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        out_almostfull = afMode ? 1'(($urandom_range(0, 1))) : 1'b0;
    endtask

    task automatic pulseStart(input logic [15:0] off, input logic [15:0] len);
        configreg = {len, off};
        op_start  = 1'b1;
        tick();
        op_start  = 1'b0;
        configreg = $urandom;
    endtask

    task automatic waitDone(input int nDone, input int budget);
        int n;
        n = 0;
        while (doneQ.size() < nDone && n < budget) begin
            tick();
            n++;
        end
        afMode         = 1'b0;
        out_almostfull = 1'b0;
        repeat (4) tick();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mem_re"},    int'(mem_re),    0);
        checkOutput({tag, "_mem_raddr"}, int'(mem_raddr), 0);
        checkOutput({tag, "_out_we"},    int'(out_we),    0);
        checkOutput({tag, "_op_done"},   int'(op_done),   0);
        checkOutput({tag, "_busy"},      int'(busy),      0);
        checkLine({tag, "_out_wdata"},   out_wdata,       '0);
    endtask

    // Compare everything the monitor saw against the expected line sequence
    task automatic checkOp(input logic [15:0] off, input int len, input int expDone);
        checkOutput("line_count", weCycQ.size(), len);
        for (int i = 0; i < len && i < dataQ.size(); i++) begin
            checkLine($sformatf("line%0d", i), dataQ[i], lineOf(16'(off + 16'(i))));
        end
        checkOutput("read_count", addrQ.size(), len);
        for (int i = 0; i < len && i < addrQ.size(); i++) begin
            checkOutput($sformatf("addr%0d", i), int'(addrQ[i]), int'(16'(off + 16'(i))));
        end
        checkOutput("done_pulses", doneQ.size(), 1);
        if (doneQ.size() > 0) begin
            if (weCycQ.size() > 0) checkOutput("done_after_last_line", doneQ[0], weCycQ[$] + 1);
            else                   checkOutput("done_cycle_len0", doneQ[0], 2);
            if (expDone >= 0) checkOutput("done_cycle", doneQ[0], expDone);
            if (doneQ[0] >= 0 && doneQ[0] < MAX_REL) checkOutput("busy_low_at_done", int'(busyAt[doneQ[0]]), 0);
        end
        checkOutput("busy_at_cycle1", int'(busyAt[1]), 1);
        checkOutput("almostfull_respected", afViol, 0);
        if (expDone >= 0 && len > 0 && reCycQ.size() > 0 && weCycQ.size() > 0) begin
            checkOutput("first_read_cycle", reCycQ[0], 1);
            checkOutput("last_read_cycle", reCycQ[$], len);
            checkOutput("first_line_cycle", weCycQ[0], 2 + READ_LATENCY);
            checkOutput("last_line_cycle", weCycQ[$], 1 + READ_LATENCY + len);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        afMode = v.afRandom;
        clearMon();
        pulseStart(v.offset, v.length);
        waitDone(1, 3000);
        checkOp(v.offset, int'(v.length), v.expDone);
    endtask

    initial begin
        int n;
        int len;
        bit afr;

        reset          = 1'b0;
        op_start       = 1'b0;
        configreg      = '0;
        out_almostfull = 1'b0;

        // Stimulus table: directed cases first, then randomized regions
        vec[0] = '{16'h0010, 16'd8,  1'b0, expDoneOf(8)};
        vec[1] = '{16'hFFFE, 16'd4,  1'b0, expDoneOf(4)};
        vec[2] = '{16'h1234, 16'd64, 1'b1, -1};
        vec[3] = '{16'h0000, 16'd1,  1'b0, expDoneOf(1)};
        for (int i = 4; i < NUM_VEC; i++) begin
            len    = int'($urandom_range(1, 48));
            afr    = 1'($urandom_range(0, 1));
            vec[i] = '{16'($urandom), 16'(len), afr, afr ? -1 : expDoneOf(len)};
        end

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        checkResetState("reset");

        for (int i = 0; i < NUM_VEC; i++) begin
            $display("[TB] vector %0d: offset %h length %0d almostfull %0d",
                     i, vec[i].offset, vec[i].length, vec[i].afRandom);
            applyStimulus(vec[i]);
        end

        // Length 0 completes quickly and a start right after it is accepted
        $display("[TB] sequence: zero length then restart");
        afMode = 1'b0;
        clearMon();
        pulseStart(16'h0040, 16'd0);
        tick();
        tick();
        pulseStart(16'h0050, 16'd3);
        waitDone(2, 500);
        checkOutput("len0_done_pulses", doneQ.size(), 2);
        if (doneQ.size() > 1) begin
            checkOutput("len0_done_cycle", doneQ[0], 2);
            checkOutput("restart_done_cycle", doneQ[1], 3 + expDoneOf(3));
        end
        checkOutput("restart_read_count", addrQ.size(), 3);
        if (reCycQ.size() > 0) checkOutput("restart_first_read", reCycQ[0], 4);
        checkOutput("restart_line_count", dataQ.size(), 3);
        for (int i = 0; i < 3 && i < dataQ.size(); i++) begin
            checkLine($sformatf("restart_line%0d", i), dataQ[i], lineOf(16'(16'h0050 + 16'(i))));
        end

        // A start while busy is ignored, even with a different configuration
        $display("[TB] sequence: start while busy");
        afMode = 1'b0;
        clearMon();
        pulseStart(16'h0100, 16'd10);
        tick();
        tick();
        pulseStart(16'h9000, 16'd3);
        waitDone(1, 500);
        checkOp(16'h0100, 10, expDoneOf(10));

        // Reset in the middle of a transfer discards everything in flight
        $display("[TB] sequence: reset mid-transfer");
        afMode = 1'b0;
        clearMon();
        pulseStart(16'h0200, 16'd16);
        n = 0;
        while (weCycQ.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("lines_before_reset", weCycQ.size(), 5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkResetState("midreset");
        clearMon();
        repeat (20) tick();
        checkOutput("no_lines_after_reset", weCycQ.size(), 0);
        checkOutput("no_reads_after_reset", addrQ.size(), 0);
        checkOutput("no_done_after_reset", doneQ.size(), 0);
        applyStimulus('{16'h0300, 16'd3, 1'b0, expDoneOf(3)});

        monEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    // Last-resort guard in case the sequence above ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
